mcont_chnbuf_page_ctrl: RTL and testbench
=========================================

MCONT_CHNBUF_PAGE_CTRL -- requirements
Module: mcont_chnbuf_page_ctrl

Interface
REQ-001 SHALL have parameter NUM_PAGES_LOG, default 2, log2 of the number of pages in the channel buffer (4 pages).
REQ-002 SHALL have parameter CHN_NUMBER, default 0, the channel index this instance serves; informational only, not used in logic.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: channel enable.
REQ-006 SHALL have port xfer_grant, input, 1 bit: 1-cycle pulse, memory controller accepted this channel's page request.
REQ-007 SHALL have port rpage_nxt, input, 1 bit: 1-cycle pulse, controller advanced to the next buffer page (registered, per-channel).
REQ-008 SHALL have port buf_done, input, 1 bit: 1-cycle pulse, controller sequence for this channel finished, so one page is filled.
REQ-009 SHALL have port page_next, input, 1 bit: 1-cycle pulse, client has consumed the current page.
REQ-010 SHALL have port xfer_want, output, 1 bit: request a page transfer from the controller.
REQ-011 SHALL have port mem_page, output, NUM_PAGES_LOG bits: buffer page the controller writes.
REQ-012 SHALL have port cl_page, output, NUM_PAGES_LOG bits: buffer page the client reads.
REQ-013 SHALL have port pages_full, output, NUM_PAGES_LOG+1 bits: count of filled, unconsumed pages, range 0..2^NUM_PAGES_LOG.
REQ-014 SHALL have port page_ready, output, 1 bit: high when pages_full != 0.
REQ-015 SHALL have port err, output, 1 bit: sticky error flag.

Function
REQ-016 SHALL implement a state machine with three states: IDLE, REQ and BUSY.
REQ-017 IDLE->REQ SHALL occur when en=1 and pages_full < 2^NUM_PAGES_LOG.
REQ-018 REQ->BUSY SHALL occur on xfer_grant; REQ->IDLE SHALL occur if en=0 and no xfer_grant is present that cycle.
REQ-019 BUSY->IDLE SHALL occur on buf_done, regardless of en.
REQ-020 xfer_want SHALL be registered and equal 1 exactly while state==REQ, so it rises 1 cycle after the IDLE->REQ condition and falls the cycle after xfer_grant.
REQ-021 At most one transfer SHALL be outstanding; REQ SHALL NOT be entered from BUSY directly.
REQ-022 mem_page SHALL increment modulo 2^NUM_PAGES_LOG on each rpage_nxt, in any state.
REQ-023 cl_page SHALL increment modulo 2^NUM_PAGES_LOG on each accepted page_next.
REQ-024 pages_full SHALL increment by 1 on buf_done in BUSY.
REQ-025 pages_full SHALL decrement by 1 on page_next when pages_full != 0.
REQ-026 Simultaneous buf_done and accepted page_next SHALL leave pages_full unchanged, while cl_page still advances.
REQ-027 page_next with pages_full==0 SHALL be ignored (no pointer or count change) and SHALL set err.
REQ-028 buf_done outside BUSY SHALL be ignored and SHALL set err.
REQ-029 buf_done in BUSY with pages_full==2^NUM_PAGES_LOG SHALL set err and SHALL saturate the count.
REQ-030 xfer_grant outside REQ SHALL be ignored.
REQ-031 When en=0 and state is IDLE, pages_full, mem_page and cl_page SHALL clear to 0 on the next posedge; err SHALL persist.
REQ-032 When en drops in BUSY, the block SHALL wait for buf_done, go to IDLE, then clear per REQ-031 on the following cycle if en is still 0.
REQ-033 page_ready SHALL be derived combinationally from the registered pages_full, adding no extra latency.

Reset
REQ-034 rst=1 at a posedge SHALL set state=IDLE, xfer_want=0, mem_page=0, cl_page=0, pages_full=0 and err=0, overriding all other inputs that cycle.
REQ-035 Reset asserted mid-transfer (BUSY) SHALL abandon the transfer; a later buf_done then sets err per REQ-028.
REQ-036 err SHALL be cleared only by rst.

Verification
REQ-037 Scenario: rst, then en=1 -> xfer_want=1 on 2nd cycle after en; xfer_grant -> xfer_want=0 next cycle; 4 rpage_nxt pulses + buf_done -> mem_page=0 (wrapped), pages_full=1, page_ready=1.
REQ-038 Scenario: 4 grant/buf_done cycles with no page_next -> pages_full=4, xfer_want stays 0; one page_next -> cl_page=1, pages_full=3, xfer_want=1 two cycles later.
REQ-039 Scenario: buf_done and page_next in the same cycle with pages_full=2 -> pages_full=2, cl_page+1.
REQ-040 Scenario: page_next with pages_full=0 -> err=1, cl_page unchanged; err held through en toggling until rst.
REQ-041 Scenario: en=0 while BUSY with pages_full=2 -> counts held until buf_done; pages_full=3 one cycle after buf_done, then 0 with both pointers=0 the cycle after.
REQ-042 Scenario: rst during BUSY, then a buf_done pulse -> all outputs 0 after rst, then err=1 after buf_done.

Source files
------------

// File: rtl/mcont_chnbuf_page_ctrl.sv
// Page bookkeeping for one memory-controller channel buffer.
// Tracks the page the controller writes, the page the client reads, and
// how many filled pages are waiting. It requests one transfer at a time
// from the controller whenever a free page exists.
module mcont_chnbuf_page_ctrl #(
  parameter int NUM_PAGES_LOG = 2,
  parameter int CHN_NUMBER    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     xfer_grant,
  input  logic                     rpage_nxt,
  input  logic                     buf_done,
  input  logic                     page_next,
  output logic                     xfer_want,
  output logic [NUM_PAGES_LOG-1:0] mem_page,
  output logic [NUM_PAGES_LOG-1:0] cl_page,
  output logic [NUM_PAGES_LOG:0]   pages_full,
  output logic                     page_ready,
  output logic                     err
);

  localparam int                   NUM_PAGES = 1 << NUM_PAGES_LOG;
  localparam logic [NUM_PAGES_LOG:0] FULL    = (NUM_PAGES_LOG+1)'(NUM_PAGES);

  // The channel index only labels the instance; a negative value
  // elaborates nothing, which keeps the parameter referenced.
  if (CHN_NUMBER < 0) begin : g_chn_chk
  end

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_BUSY} state_t;

  state_t state, state_nxt;

  logic done_ok;   // buf_done while a transfer is actually outstanding
  logic pg_ok;     // page_next with something to consume
  logic not_full;  // at least one free page
  logic clr;       // disabled and quiet: drop all buffer state

  assign done_ok    = buf_done && (state == ST_BUSY);
  assign pg_ok      = page_next && (pages_full != '0);
  assign not_full   = (pages_full != FULL);
  assign clr        = !en && (state == ST_IDLE);
  assign page_ready = (pages_full != '0);

  // Next-state: only one transfer in flight, BUSY always returns via IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en && not_full) state_nxt = ST_REQ;
      ST_REQ: begin
        if (xfer_grant)  state_nxt = ST_BUSY;
        else if (!en)    state_nxt = ST_IDLE;
      end
      ST_BUSY: if (buf_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; xfer_want is registered alongside so it tracks REQ exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      xfer_want <= 1'b0;
    end else begin
      state     <= state_nxt;
      xfer_want <= (state_nxt == ST_REQ);
    end
  end

  // Page pointers and fill count; clearing while disabled wins over updates.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      mem_page   <= '0;
      cl_page    <= '0;
      pages_full <= '0;
    end else begin
      if (rpage_nxt) mem_page <= mem_page + 1'b1;
      if (pg_ok)     cl_page  <= cl_page + 1'b1;
      case ({done_ok, pg_ok})
        2'b10:   if (not_full) pages_full <= pages_full + 1'b1;
        2'b01:   pages_full <= pages_full - 1'b1;
        default: pages_full <= pages_full;
      endcase
    end
  end

  // Sticky error: consume from empty, stray buf_done, or fill past capacity.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((page_next && (pages_full == '0)) ||
                 (buf_done && (state != ST_BUSY)) ||
                 (done_ok && !not_full && !pg_ok)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mcont_chnbuf_page_ctrl.sv
// Directed bench for mcont_chnbuf_page_ctrl with hand-computed expectations.
module tb_mcont_chnbuf_page_ctrl;

  localparam int NPL = 2;

  logic           clk = 1'b0;
  logic           rst, en, xfer_grant, rpage_nxt, buf_done, page_next;
  logic           xfer_want, page_ready, err;
  logic [NPL-1:0] mem_page, cl_page;
  logic [NPL:0]   pages_full;

  int n_vec = 0;
  int n_err = 0;

  mcont_chnbuf_page_ctrl #(.NUM_PAGES_LOG(NPL), .CHN_NUMBER(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .xfer_grant (xfer_grant),
    .rpage_nxt  (rpage_nxt),
    .buf_done   (buf_done),
    .page_next  (page_next),
    .xfer_want  (xfer_want),
    .mem_page   (mem_page),
    .cl_page    (cl_page),
    .pages_full (pages_full),
    .page_ready (page_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // advance one clock, settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_grant();
    xfer_grant = 1'b1; tick(); xfer_grant = 1'b0;
  endtask

  task automatic pulse_done();
    buf_done = 1'b1; tick(); buf_done = 1'b0;
  endtask

  task automatic pulse_pnext();
    page_next = 1'b1; tick(); page_next = 1'b0;
  endtask

  task automatic pulse_rpage();
    rpage_nxt = 1'b1; tick(); rpage_nxt = 1'b0;
  endtask

  // full transfer: wait (bounded) for a request, grant it, finish it
  task automatic do_xfer(input string tag);
    int n = 0;
    while (xfer_want !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_req_seen"}, int'(xfer_want), 1);
    pulse_grant();
    pulse_done();
  endtask

  task automatic chk_all(input string tag, input int mp, input int cp,
                         input int pf, input int w, input int e);
    chk({tag, "_mem_page"},   int'(mem_page),   mp);
    chk({tag, "_cl_page"},    int'(cl_page),    cp);
    chk({tag, "_pages_full"}, int'(pages_full), pf);
    chk({tag, "_page_ready"}, int'(page_ready), (pf != 0) ? 1 : 0);
    chk({tag, "_xfer_want"},  int'(xfer_want),  w);
    chk({tag, "_err"},        int'(err),        e);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; xfer_grant = 1'b0; rpage_nxt = 1'b0;
    buf_done = 1'b0; page_next = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_all("reset", 0, 0, 0, 0, 0);

    // first request, grant, controller walks 4 pages then finishes
    en = 1'b1;
    tick();
    chk("s1_want_up", int'(xfer_want), 1);
    pulse_grant();
    chk("s1_want_down", int'(xfer_want), 0);
    pulse_rpage(); pulse_rpage();
    chk("s1_mem_page_2", int'(mem_page), 2);
    pulse_rpage(); pulse_rpage();
    chk("s1_mem_wrap", int'(mem_page), 0);
    pulse_done();
    chk_all("s1_done", 0, 0, 1, 0, 0);

    // fill the buffer completely with nobody consuming
    do_xfer("s2a"); do_xfer("s2b"); do_xfer("s2c");
    chk("s2_full4", int'(pages_full), 4);
    tick(); tick(); tick();
    chk("s2_no_req_when_full", int'(xfer_want), 0);
    pulse_pnext();
    chk_all("s2_consume", 0, 1, 3, 0, 0);
    tick();
    chk("s2_req_resume", int'(xfer_want), 1);

    // simultaneous fill and consume with two pages waiting
    pulse_pnext();
    chk("s3_pf2", int'(pages_full), 2);
    pulse_grant();
    buf_done = 1'b1; page_next = 1'b1;
    tick();
    buf_done = 1'b0; page_next = 1'b0;
    chk_all("s3_both", 0, 3, 2, 0, 0);

    // disable while busy: hold until buf_done, then clear a cycle later
    tick();
    chk("s5_req", int'(xfer_want), 1);
    pulse_grant();
    en = 1'b0;
    pulse_rpage();
    tick();
    chk_all("s5_hold", 1, 3, 2, 0, 0);
    pulse_done();
    chk_all("s5_done", 1, 3, 3, 0, 0);
    tick();
    chk_all("s5_clear", 0, 0, 0, 0, 0);

    // consume from empty buffer flags error, pointer untouched
    en = 1'b1;
    tick();
    pulse_grant();
    pulse_done();
    pulse_pnext();
    chk("s4_cl1", int'(cl_page), 1);
    chk("s4_pf0", int'(pages_full), 0);
    pulse_pnext();
    chk("s4_cl_hold", int'(cl_page), 1);
    chk("s4_err", int'(err), 1);
    en = 1'b0; tick(); tick();
    chk("s4_err_en0", int'(err), 1);
    en = 1'b1; tick(); tick();
    chk("s4_err_en1", int'(err), 1);

    // reset mid-transfer abandons it; a late buf_done is an error
    pulse_grant();
    en = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk_all("s6_rst", 0, 0, 0, 0, 0);
    pulse_grant();
    chk("s6_grant_ignored", int'(xfer_want), 0);
    pulse_done();
    chk("s6_stray_done_err", int'(err), 1);
    chk("s6_stray_done_pf", int'(pages_full), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
